// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared encodings for the AXI read master: burst and size codes, FSM state
// encoding, beat FIFO geometry, and the command sanitising helpers.
// ---------------------------------------------------------------------------
package axi_pkg;

    // Beat FIFO geometry
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_AW    = 2;

    // Longest burst this master issues is 4 beats (ARLEN = 3)
    localparam logic [3:0] MAX_LEN = 4'd3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    // Code 2'b11 (8 bytes) is wider than the bus and is never issued
    typedef enum logic [1:0] {
        SIZE_1B = 2'b00,
        SIZE_2B = 2'b01,
        SIZE_4B = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_e;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    function automatic logic [1:0] clamp_size(input logic [1:0] size);
        return (size == 2'b11) ? SIZE_4B : size;
    endfunction

endpackage

// File: rtl/beat_fifo.sv
// ---------------------------------------------------------------------------
// beat_fifo
// Small synchronous FIFO holding returned read beats until the user takes
// them. Push and pop in the same cycle leave the count unchanged, and a push
// into a full FIFO is accepted when a pop frees the head slot that cycle.
//
// Ports
//   ACLK, ARESETn   clock, async active-low reset
//   push_i/wdata_i  write strobe and entry
//   pop_i           consume head entry (ignored when empty)
//   rdata_o         head entry (zero when empty after reset)
//   full_o/empty_o  occupancy flags
// ---------------------------------------------------------------------------
module beat_fifo
    import axi_pkg::*;
#(
    parameter int Width = 35
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [Width-1:0]   mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (cnt_q == (FIFO_AW+1)'(FIFO_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/read_master.sv
// ---------------------------------------------------------------------------
// read_master
// Single-outstanding AXI3 read master. A user command is latched in IDLE,
// issued on AR in ADDR, and its beats are collected in DATA into a 4-entry
// FIFO which feeds the user rd_* stream.
//
// Ports
//   ACLK, ARESETn        clock, async active-low reset
//   cmd_*                user request (valid/ready), latched on handshake
//   AR*                  AXI read address channel (lock/cache/prot tied 0)
//   R*                   AXI read data channel
//   rd_*                 buffered beats to the user (valid/ready)
//   busy                 command in flight or beats still buffered
//   err                  sticky: foreign RID or RLAST/beat-count disagreement;
//                        cleared by the next command handshake
// ---------------------------------------------------------------------------
module read_master
    import axi_pkg::*;
#(
    parameter int BusWidth  = 32,
    parameter int TagBits   = 2,
    parameter int MasterSel = 0
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    // user command
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [BusWidth-1:0] cmd_addr,
    input  logic [3:0]          cmd_len,
    input  logic [1:0]          cmd_size,
    input  logic [1:0]          cmd_burst,
    input  logic [TagBits-2:0]  cmd_id,
    // AXI read address
    output logic [TagBits-1:0]  ARID,
    output logic [BusWidth-1:0] ARADDR,
    output logic [3:0]          ARLEN,
    output logic [1:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic [1:0]          ARLOCK,
    output logic [3:0]          ARCACHE,
    output logic [2:0]          ARPROT,
    output logic                ARVALID,
    input  logic                ARREADY,
    // AXI read data
    input  logic [TagBits-1:0]  RID,
    input  logic [BusWidth-1:0] RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY,
    // user beat stream
    output logic [BusWidth-1:0] rd_data,
    output logic [1:0]          rd_resp,
    output logic                rd_last,
    output logic                rd_valid,
    input  logic                rd_ready,
    // status
    output logic                busy,
    output logic                err
);

    localparam int FifoW = BusWidth + 3;

    state_e              state_q;
    logic                cmd_ready_q;
    logic                arvalid_q;
    logic [TagBits-1:0]  arid_q;
    logic [BusWidth-1:0] araddr_q;
    logic [3:0]          arlen_q;
    logic [1:0]          arsize_q;
    logic [1:0]          arburst_q;
    logic [2:0]          cnt_q;
    logic                err_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic [FifoW-1:0]    fifo_rdata;

    logic                cmd_hs;
    logic                ar_hs;
    logic                beat_acc;
    logic                id_ok;
    logic                cnt_one;
    logic                beat_final;
    logic                beat_push;

    assign cmd_hs   = cmd_valid & cmd_ready_q;
    assign ar_hs    = arvalid_q & ARREADY;
    assign RREADY   = (state_q == ST_DATA) & ~fifo_full;
    assign beat_acc = RVALID & RREADY;
    assign id_ok    = (RID == arid_q);
    assign cnt_one  = (cnt_q == 3'd1);

    // A matching beat closes the burst either when the slave flags RLAST or
    // when the counter says it must be the final one; whichever comes first
    // wins, so a misbehaving slave can never wedge the FSM in DATA.
    assign beat_final = RLAST | cnt_one;
    assign beat_push  = beat_acc & id_ok;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            arid_q      <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arsize_q    <= '0;
            arburst_q   <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // cmd_ready is 0 during reset and rises on the first edge
                    // after release; afterwards it tracks IDLE.
                    cmd_ready_q <= 1'b1;
                    if (cmd_hs) begin
                        state_q     <= ST_ADDR;
                        cmd_ready_q <= 1'b0;
                        arvalid_q   <= 1'b1;
                        arid_q      <= {1'(MasterSel), cmd_id};
                        araddr_q    <= cmd_addr;
                        arlen_q     <= clamp_len(cmd_len);
                        arsize_q    <= clamp_size(cmd_size);
                        arburst_q   <= cmd_burst;
                        err_q       <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (ar_hs) begin
                        state_q   <= ST_DATA;
                        arvalid_q <= 1'b0;
                        cnt_q     <= 3'(arlen_q) + 3'd1;
                    end
                end
                ST_DATA: begin
                    if (beat_acc) begin
                        if (!id_ok) begin
                            // foreign beat: swallowed, counter untouched
                            err_q <= 1'b1;
                        end else begin
                            if (RLAST != cnt_one) err_q <= 1'b1;
                            if (beat_final) begin
                                state_q     <= ST_IDLE;
                                cmd_ready_q <= 1'b1;
                                cnt_q       <= '0;
                            end else begin
                                cnt_q <= cnt_q - 3'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    arvalid_q   <= 1'b0;
                end
            endcase
        end
    end

    beat_fifo #(
        .Width (FifoW)
    ) u_fifo (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .push_i  (beat_push),
        .wdata_i ({beat_final, RRESP, RDATA}),
        .pop_i   (rd_ready),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cmd_ready = cmd_ready_q;
    assign ARVALID   = arvalid_q;
    assign ARID      = arid_q;
    assign ARADDR    = araddr_q;
    assign ARLEN     = arlen_q;
    assign ARSIZE    = arsize_q;
    assign ARBURST   = arburst_q;
    assign ARLOCK    = 2'b00;
    assign ARCACHE   = 4'b0000;
    assign ARPROT    = 3'b000;

    assign rd_data   = fifo_rdata[BusWidth-1:0];
    assign rd_resp   = fifo_rdata[BusWidth+1:BusWidth];
    assign rd_last   = fifo_rdata[BusWidth+2];
    assign rd_valid  = ~fifo_empty;

    assign busy      = (state_q != ST_IDLE) | ~fifo_empty;
    assign err       = err_q;

endmodule

// File: tb/tb_read_master.sv
module tb_read_master;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic [1:0]  cmd_size = '0;
    logic [1:0]  cmd_burst = '0;
    logic [0:0]  cmd_id = '0;
    logic [1:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [1:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [1:0]  ARLOCK;
    logic [3:0]  ARCACHE;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [1:0]  RID = '0;
    logic [31:0] RDATA = '0;
    logic [1:0]  RRESP = '0;
    logic        RLAST = 1'b0;
    logic        RVALID = 1'b0;
    logic        RREADY;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        rd_last;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // {last, resp, data} of every beat the user side consumes
    logic [34:0] got_q [$];

    always #5 ACLK = ~ACLK;

    read_master #(.BusWidth(32), .TagBits(2), .MasterSel(1)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .err(err)
    );

    always @(posedge ACLK) begin
        if (ARESETn && rd_valid && rd_ready) got_q.push_back({rd_last, rd_resp, rd_data});
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic issue_cmd(input logic [31:0] a, input logic [3:0] l, input logic [1:0] s,
                             input logic [1:0] b, input logic id);
        cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b; cmd_id = id;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic ar_handshake();
        ARREADY = 1'b1;
        step();
        ARREADY = 1'b0;
    endtask

    task automatic send_beat(input logic [1:0] id, input logic [31:0] d, input logic [1:0] r, input logic l);
        bit acc = 0;
        RID = id; RDATA = d; RRESP = r; RLAST = l; RVALID = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (RREADY) acc = 1;
            step();
        end
        RVALID = 1'b0; RLAST = 1'b0;
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL r_handshake timeout: RREADY never high (data %h)", d);
        end
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        step(2);
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
        n_checks++; if ({ARVALID, RREADY, rd_valid, busy, err} !== 5'b0) begin n_fail++; $display("FAIL rst_outputs got %b exp 00000", {ARVALID, RREADY, rd_valid, busy, err}); end
        n_checks++; if ({ARID, ARADDR, ARLEN} !== 38'b0) begin n_fail++; $display("FAIL rst_ar_fields got %h exp 0", {ARID, ARADDR, ARLEN}); end
        ARESETn = 1'b1;
        step();
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_cmd_ready got %b exp 1", cmd_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_d [4];
        exp_d[0] = 32'hDEADBEEF; exp_d[1] = 32'h1; exp_d[2] = 32'h2; exp_d[3] = 32'h3;
        got_q.delete();
        rd_ready = 1'b1;
        issue_cmd(32'h100, 4'd3, 2'b10, 2'b01, 1'b1);
        n_checks++; if (ARVALID !== 1'b1) begin n_fail++; $display("FAIL basic_arvalid got %b exp 1", ARVALID); end
        n_checks++; if (ARID !== 2'b11) begin n_fail++; $display("FAIL basic_arid got %b exp 11", ARID); end
        n_checks++; if ({ARADDR, ARLEN, ARSIZE, ARBURST} !== {32'h100, 4'd3, 2'b10, 2'b01}) begin n_fail++; $display("FAIL basic_ar_fields got %h %h %b %b exp 100 3 10 01", ARADDR, ARLEN, ARSIZE, ARBURST); end
        n_checks++; if ({ARLOCK, ARCACHE, ARPROT} !== 9'b0) begin n_fail++; $display("FAIL basic_ar_ties got %b exp 0", {ARLOCK, ARCACHE, ARPROT}); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL basic_cmd_ready got %b exp 0", cmd_ready); end
        ar_handshake();
        n_checks++; if (ARVALID !== 1'b0) begin n_fail++; $display("FAIL basic_arvalid_drop got %b exp 0", ARVALID); end
        send_beat(2'b11, exp_d[0], 2'b00, 1'b0);
        // beat accepted on the previous edge is visible now
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_first_latency got v=%b d=%h exp v=1 d=deadbeef", rd_valid, rd_data); end
        for (int i = 1; i < 4; i++) send_beat(2'b11, exp_d[i], 2'b00, i == 3);
        step(3);
        n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL basic_beat_count got %0d exp 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== {(i == 3), 2'b00, exp_d[i]}) begin n_fail++; $display("FAIL basic_beat%0d got %h exp %h", i, got_q[i], {(i == 3), 2'b00, exp_d[i]}); end
        end
        n_checks++; if ({cmd_ready, busy, err} !== 3'b100) begin n_fail++; $display("FAIL basic_done got rdy/busy/err %b exp 100", {cmd_ready, busy, err}); end
    endtask

    task automatic test_arready_stall();
        got_q.delete();
        rd_ready = 1'b1;
        issue_cmd(32'h2000, 4'd0, 2'b01, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (ARVALID !== 1'b1 || ARADDR !== 32'h2000 || cmd_ready !== 1'b0 || ARID !== 2'b10) begin
                n_fail++; $display("FAIL stall_cycle%0d got v=%b a=%h rdy=%b id=%b exp 1 2000 0 10", i, ARVALID, ARADDR, cmd_ready, ARID);
            end
            step();
        end
        ar_handshake();
        send_beat(2'b10, 32'hCAFE0001, 2'b10, 1'b1);
        step(2);
        n_checks++; if (got_q.size() != 1 || got_q[0] !== {1'b1, 2'b10, 32'hCAFE0001}) begin n_fail++; $display("FAIL stall_beat got n=%0d exp one beat 1_10_cafe0001", got_q.size()); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL stall_slverr_no_err got %b exp 0", err); end
    endtask

    task automatic test_backpressure();
        got_q.delete();
        rd_ready = 1'b0;
        issue_cmd(32'h40, 4'd3, 2'b10, 2'b01, 1'b1);
        ar_handshake();
        for (int i = 0; i < 4; i++) send_beat(2'b11, 32'hA0 + i, 2'(i), i == 3);
        n_checks++; if (RREADY !== 1'b0) begin n_fail++; $display("FAIL bp_rready got %b exp 0", RREADY); end
        n_checks++; if (rd_valid !== 1'b1 || busy !== 1'b1 || rd_data !== 32'hA0) begin n_fail++; $display("FAIL bp_held got v=%b busy=%b d=%h exp 1 1 a0", rd_valid, busy, rd_data); end
        step(3);
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL bp_no_pop got %0d exp 0", got_q.size()); end
        rd_ready = 1'b1;
        step(6);
        n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL bp_count got %0d exp 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== {(i == 3), 2'(i), 32'hA0 + i}) begin n_fail++; $display("FAIL bp_beat%0d got %h exp %h", i, got_q[i], {(i == 3), 2'(i), 32'hA0 + i}); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy got %b exp 0", busy); end
    endtask

    task automatic test_bad_id();
        got_q.delete();
        rd_ready = 1'b1;
        issue_cmd(32'h300, 4'd1, 2'b10, 2'b01, 1'b1);
        ar_handshake();
        send_beat(2'b01, 32'hBAD0BAD0, 2'b00, 1'b1);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL badid_err got %b exp 1", err); end
        n_checks++; if (rd_valid !== 1'b0 || RREADY !== 1'b1) begin n_fail++; $display("FAIL badid_dropped got v=%b rready=%b exp 0 1", rd_valid, RREADY); end
        send_beat(2'b11, 32'h11, 2'b00, 1'b0);
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL badid_cnt_kept got cmd_ready %b exp 0", cmd_ready); end
        send_beat(2'b11, 32'h22, 2'b00, 1'b1);
        step(2);
        n_checks++; if (cmd_ready !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL badid_end got rdy=%b err=%b exp 1 1", cmd_ready, err); end
        n_checks++; if (got_q.size() != 2 || got_q[0] !== {1'b0, 2'b00, 32'h11} || got_q[1] !== {1'b1, 2'b00, 32'h22}) begin n_fail++; $display("FAIL badid_beats got n=%0d exp 2 good beats", got_q.size()); end
    endtask

    task automatic test_early_last();
        got_q.delete();
        rd_ready = 1'b1;
        issue_cmd(32'h500, 4'd7, 2'b11, 2'b10, 1'b0);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL early_err_clear got %b exp 0", err); end
        n_checks++; if (ARLEN !== 4'd3 || ARSIZE !== 2'b10 || ARBURST !== 2'b10) begin n_fail++; $display("FAIL early_clamp got len=%0d size=%b burst=%b exp 3 10 10", ARLEN, ARSIZE, ARBURST); end
        ar_handshake();
        send_beat(2'b10, 32'h51, 2'b00, 1'b0);
        send_beat(2'b10, 32'h52, 2'b00, 1'b1);
        n_checks++; if (err !== 1'b1 || cmd_ready !== 1'b1 || RREADY !== 1'b0) begin n_fail++; $display("FAIL early_end got err=%b rdy=%b rready=%b exp 1 1 0", err, cmd_ready, RREADY); end
        step(2);
        n_checks++; if (got_q.size() != 2 || got_q[1] !== {1'b1, 2'b00, 32'h52}) begin n_fail++; $display("FAIL early_beats got n=%0d exp 2, last on 2nd", got_q.size()); end
    endtask

    task automatic test_missing_last();
        got_q.delete();
        rd_ready = 1'b1;
        issue_cmd(32'h600, 4'd1, 2'b10, 2'b01, 1'b0);
        ar_handshake();
        send_beat(2'b10, 32'h61, 2'b00, 1'b0);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL miss_mid_err got %b exp 0", err); end
        send_beat(2'b10, 32'h62, 2'b00, 1'b0);
        step(2);
        n_checks++; if (err !== 1'b1 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL miss_end got err=%b rdy=%b exp 1 1", err, cmd_ready); end
        n_checks++; if (got_q.size() != 2 || got_q[1] !== {1'b1, 2'b00, 32'h62}) begin n_fail++; $display("FAIL miss_rd_last got n=%0d exp 2, forced last", got_q.size()); end
    endtask

    task automatic test_mid_reset();
        got_q.delete();
        rd_ready = 1'b0;
        issue_cmd(32'h700, 4'd3, 2'b10, 2'b01, 1'b1);
        ar_handshake();
        send_beat(2'b11, 32'h71, 2'b00, 1'b0);
        send_beat(2'b11, 32'h72, 2'b00, 1'b0);
        ARESETn = 1'b0;
        #1;
        n_checks++; if ({cmd_ready, ARVALID, RREADY, rd_valid, rd_last, busy, err} !== 7'b0) begin n_fail++; $display("FAIL mrst_flags got %b exp 0000000", {cmd_ready, ARVALID, RREADY, rd_valid, rd_last, busy, err}); end
        n_checks++; if ({ARADDR, ARID, ARLEN, rd_data, rd_resp} !== 72'b0) begin n_fail++; $display("FAIL mrst_data got %h exp 0", {ARADDR, ARID, ARLEN, rd_data, rd_resp}); end
        step(2);
        ARESETn = 1'b1;
        step();
        n_checks++; if (cmd_ready !== 1'b1 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_release got rdy=%b v=%b exp 1 0", cmd_ready, rd_valid); end
        rd_ready = 1'b1;
        issue_cmd(32'h800, 4'd1, 2'b10, 2'b01, 1'b0);
        ar_handshake();
        send_beat(2'b10, 32'h81, 2'b00, 1'b0);
        send_beat(2'b10, 32'h82, 2'b00, 1'b1);
        step(2);
        n_checks++; if (got_q.size() != 2 || got_q[0] !== {1'b0, 2'b00, 32'h81} || got_q[1] !== {1'b1, 2'b00, 32'h82}) begin n_fail++; $display("FAIL mrst_fresh got n=%0d exp 2 fresh beats", got_q.size()); end
        n_checks++; if ({cmd_ready, busy, err} !== 3'b100) begin n_fail++; $display("FAIL mrst_done got %b exp 100", {cmd_ready, busy, err}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arready_stall();
        test_backpressure();
        test_bad_id();
        test_early_last();
        test_missing_last();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
